alu_ex_stage: RTL and testbench

Execute stage of the MIPS pipeline, directly downstream of the ALU control unit. Consumes the 3-bit ALU function code and ID/EX operands, computes the result, and holds it in the EX/MEM pipeline register with stall, flush and valid tracking. Downstream MEM/WB logic reads only registered outputs; nothing combinational crosses the stage boundary.

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_core.sv | 57 +++++
 rtl/alu_ex_stage.sv | 130 +++++++++++++
 tb/tb_alu_ex_stage.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_pkg: ALU function codes, R-type funct fields, NOP helper       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package alu_pkg;

   // 3-bit function codes driven by ALU control
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_NOP = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // R-type funct fields shared with ALU control
   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   // Anything that is not one of the five real operations behaves as NOP.
   function automatic logic is_nop(input logic [2:0] func);
      logic real_op;
      real_op = (func == ALU_ADD) || (func == ALU_SUB) || (func == ALU_AND) ||
                (func == ALU_OR)  || (func == ALU_SLT);
      return !real_op;
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_core.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_core: combinational ALU (result, zero, overflow)               |
// | Optional: ALU_EX_OVF_EN adds signed-overflow output                |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       alu_func,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic [WIDTH-1:0] result,
`ifdef ALU_EX_OVF_EN
   output logic             ovf,
`endif
   output logic             zero
);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_lt;

   assign w_sum  = op_a + op_b;
   assign w_diff = op_a - op_b;
   assign w_lt   = $signed(op_a) < $signed(op_b);

   always_comb begin
      result = '0;
      case (alu_func)
         ALU_ADD: result = w_sum;
         ALU_SUB: result = w_diff;
         ALU_AND: result = op_a & op_b;
         ALU_OR:  result = op_a | op_b;
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_lt};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

`ifdef ALU_EX_OVF_EN
   // ADD: like signs in, unlike sign out. SUB: unlike signs in, result sign departs from op_a.
   always_comb begin
      ovf = 1'b0;
      case (alu_func)
         ALU_ADD: ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_sum[WIDTH-1]  != op_a[WIDTH-1]);
         ALU_SUB: ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_diff[WIDTH-1] != op_a[WIDTH-1]);
         default: ovf = 1'b0;
      endcase
   end
`endif

endmodule : alu_core
`default_nettype wire

// File: rtl/alu_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alu_ex_stage: MIPS execute stage with EX/MEM pipeline register     |
// | Optional: ALU_EX_OVF_EN adds ovf output and overflow write-kill    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module alu_ex_stage
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [2:0]         alu_func,
   input  logic [WIDTH-1:0]   op_a,
   input  logic [WIDTH-1:0]   op_b,
   input  logic [RADDR_W-1:0] dest_in,
   input  logic               wen_in,
   output logic               out_valid,
   output logic [WIDTH-1:0]   result,
   output logic               zero,
   output logic [RADDR_W-1:0] dest_out,
`ifdef ALU_EX_OVF_EN
   output logic               ovf,
`endif
   output logic               wen_out
);

   logic [WIDTH-1:0]   w_result;
   logic               w_zero;
   logic               w_wen_eff;

   logic               valid_q,  valid_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q,   zero_d;
   logic [RADDR_W-1:0] dest_q,   dest_d;
   logic               wen_q,    wen_d;

`ifdef ALU_EX_OVF_EN
   logic               w_ovf;
   logic               ovf_q, ovf_d;
`endif

   alu_core #(
      .WIDTH    (WIDTH)
   ) u_alu_core (
      .alu_func (alu_func),
      .op_a     (op_a),
      .op_b     (op_b),
      .result   (w_result),
`ifdef ALU_EX_OVF_EN
      .ovf      (w_ovf),
`endif
      .zero     (w_zero)
   );

   // Writes to r0 and from NOP/invalid slots never reach the register file.
`ifdef ALU_EX_OVF_EN
   assign w_wen_eff = in_valid & wen_in & ~is_nop(alu_func) & (dest_in != '0) & ~w_ovf;
`else
   assign w_wen_eff = in_valid & wen_in & ~is_nop(alu_func) & (dest_in != '0);
`endif

   always_comb begin
      valid_d  = valid_q;
      result_d = result_q;
      zero_d   = zero_q;
      dest_d   = dest_q;
      wen_d    = wen_q;
`ifdef ALU_EX_OVF_EN
      ovf_d    = ovf_q;
`endif
      if (flush) begin
         valid_d  = 1'b0;
         result_d = '0;
         zero_d   = 1'b0;
         dest_d   = '0;
         wen_d    = 1'b0;
`ifdef ALU_EX_OVF_EN
         ovf_d    = 1'b0;
`endif
      end else if (!stall) begin
         valid_d  = in_valid;
         result_d = w_result;
         zero_d   = w_zero;
         dest_d   = dest_in;
         wen_d    = w_wen_eff;
`ifdef ALU_EX_OVF_EN
         ovf_d    = w_ovf;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q  <= 1'b0;
         result_q <= '0;
         zero_q   <= 1'b0;
         dest_q   <= '0;
         wen_q    <= 1'b0;
`ifdef ALU_EX_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         valid_q  <= valid_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         dest_q   <= dest_d;
         wen_q    <= wen_d;
`ifdef ALU_EX_OVF_EN
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign out_valid = valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign dest_out  = dest_q;
   assign wen_out   = wen_q;
`ifdef ALU_EX_OVF_EN
   assign ovf       = ovf_q;
`endif

endmodule : alu_ex_stage
`default_nettype wire

// File: tb/tb_alu_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alu_ex_stage: directed self-checking bench for alu_ex_stage     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_alu_ex_stage;

`ifdef ALU_EX_OVF_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        in_valid;
   logic [2:0]  alu_func;
   logic [31:0] op_a;
   logic [31:0] op_b;
   logic [4:0]  dest_in;
   logic        wen_in;
   logic        out_valid;
   logic [31:0] result;
   logic        zero;
   logic [4:0]  dest_out;
   logic        wen_out;
`ifdef ALU_EX_OVF_EN
   logic        ovf;
`endif

   int n_total;
   int n_pass;

   alu_ex_stage #(
      .WIDTH     (32),
      .RADDR_W   (5)
   ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .stall     (stall),
      .flush     (flush),
      .in_valid  (in_valid),
      .alu_func  (alu_func),
      .op_a      (op_a),
      .op_b      (op_b),
      .dest_in   (dest_in),
      .wen_in    (wen_in),
      .out_valid (out_valid),
      .result    (result),
      .zero      (zero),
      .dest_out  (dest_out),
`ifdef ALU_EX_OVF_EN
      .ovf       (ovf),
`endif
      .wen_out   (wen_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic w);
      in_valid = v;
      alu_func = f;
      op_a     = a;
      op_b     = b;
      dest_in  = d;
      wen_in   = w;
   endtask

   // Advance one edge and settle away from it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_valid"},  out_valid, 0);
      check_eq({tag, "_result"}, result,    0);
      check_eq({tag, "_zero"},   zero,      0);
      check_eq({tag, "_dest"},   dest_out,  0);
      check_eq({tag, "_wen"},    wen_out,   0);
`ifdef ALU_EX_OVF_EN
      check_eq({tag, "_ovf"},    ovf,       0);
`endif
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      rst     = 1'b1;
      stall   = 1'b0;
      flush   = 1'b0;
      drive(1'b0, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0);

      // Reset held two cycles with random inputs
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 3'b010, $urandom, $urandom, 5'($urandom_range(1, 31)), 1'b1);
         tick();
      end
      check_cleared("reset");
      rst = 1'b0;

      // ADD signed overflow case
      drive(1'b1, 3'b010, 32'h7FFF_FFFF, 32'h1, 5'd3, 1'b1);
      tick();
      check_eq("add_result", result, 32'h8000_0000);
      check_eq("add_zero",   zero,   0);
      check_eq("add_valid",  out_valid, 1);
      check_eq("add_dest",   dest_out, 5'd3);
      check_eq("add_wen",    wen_out, OVF_EN ? 0 : 1);
`ifdef ALU_EX_OVF_EN
      check_eq("add_ovf",    ovf, 1);
`endif

      // ADD wrap to zero, no overflow (mixed signs)
      drive(1'b1, 3'b010, 32'hFFFF_FFFF, 32'h1, 5'd4, 1'b1);
      tick();
      check_eq("addwrap_result", result, 32'h0);
      check_eq("addwrap_zero",   zero,   1);
      check_eq("addwrap_wen",    wen_out, 1);

      // SLT signed: -1 < 1
      drive(1'b1, 3'b111, 32'hFFFF_FFFF, 32'h1, 5'd5, 1'b1);
      tick();
      check_eq("slt_result", result, 32'h1);
      check_eq("slt_zero",   zero,   0);

      // SLT false: 1 < -1 is false
      drive(1'b1, 3'b111, 32'h1, 32'hFFFF_FFFF, 5'd5, 1'b1);
      tick();
      check_eq("slt_false", result, 32'h0);

      // SUB equal operands
      drive(1'b1, 3'b110, 32'd5, 32'd5, 5'd6, 1'b1);
      tick();
      check_eq("sub_result", result, 32'h0);
      check_eq("sub_zero",   zero,   1);
      check_eq("sub_wen",    wen_out, 1);

      // SUB overflow: 0x80000000 - 1
      drive(1'b1, 3'b110, 32'h8000_0000, 32'h1, 5'd6, 1'b1);
      tick();
      check_eq("subovf_result", result, 32'h7FFF_FFFF);
      check_eq("subovf_wen",    wen_out, OVF_EN ? 0 : 1);

      // AND / OR
      drive(1'b1, 3'b000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd8, 1'b1);
      tick();
      check_eq("and_result", result, 32'h00F0_1200);
      drive(1'b1, 3'b001, 32'hF000_00F0, 32'h0000_0F0F, 5'd8, 1'b1);
      tick();
      check_eq("or_result", result, 32'hF000_0FFF);

      // NOP with write request
      drive(1'b1, 3'b011, 32'd3, 32'd4, 5'd7, 1'b1);
      tick();
      check_eq("nop_wen",    wen_out, 0);
      check_eq("nop_zero",   zero,    1);
      check_eq("nop_result", result,  0);
      check_eq("nop_valid",  out_valid, 1);

      // Code 101 behaves as NOP
      drive(1'b1, 3'b101, 32'd3, 32'd4, 5'd7, 1'b1);
      tick();
      check_eq("f101_result", result,  0);
      check_eq("f101_wen",    wen_out, 0);

      // Write to r0 suppressed
      drive(1'b1, 3'b010, 32'd3, 32'd4, 5'd0, 1'b1);
      tick();
      check_eq("r0_wen",    wen_out, 0);
      check_eq("r0_result", result,  32'd7);

      // Invalid slot still captures datapath
      drive(1'b0, 3'b010, 32'd2, 32'd2, 5'd9, 1'b1);
      tick();
      check_eq("inv_result", result,    32'd4);
      check_eq("inv_valid",  out_valid, 0);
      check_eq("inv_wen",    wen_out,   0);
      check_eq("inv_dest",   dest_out,  5'd9);

      // Stall holds for 3 cycles while inputs change
      drive(1'b1, 3'b010, 32'd3, 32'd4, 5'd10, 1'b1);
      tick();
      check_eq("preload_result", result, 32'd7);
      stall = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 3'b000, 32'hFF + 32'(k), 32'h0F, 5'd11, 1'b0);
         tick();
         check_eq("stall_result", result,   32'd7);
         check_eq("stall_dest",   dest_out, 5'd10);
         check_eq("stall_wen",    wen_out,  1);
      end
      stall = 1'b0;
      drive(1'b1, 3'b000, 32'hFF, 32'h0F, 5'd11, 1'b0);
      tick();
      check_eq("unstall_result", result,   32'h0F);
      check_eq("unstall_dest",   dest_out, 5'd11);
      check_eq("unstall_wen",    wen_out,  0);

      // Flush and stall together clear the slot
      drive(1'b1, 3'b010, 32'd1, 32'd1, 5'd12, 1'b1);
      tick();
      check_eq("preflush_valid", out_valid, 1);
      flush = 1'b1;
      stall = 1'b1;
      tick();
      check_cleared("flushstall");
      flush = 1'b0;
      stall = 1'b0;

      // Reset asserted mid-stall dominates
      drive(1'b1, 3'b001, 32'h1, 32'h2, 5'd13, 1'b1);
      tick();
      check_eq("prerst_result", result, 32'h3);
      stall = 1'b1;
      rst   = 1'b1;
      tick();
      check_cleared("rststall");
      rst   = 1'b0;
      stall = 1'b0;

      // First load after reset captures normally
      drive(1'b1, 3'b010, 32'd20, 32'd22, 5'd14, 1'b1);
      tick();
      check_eq("post_result", result,    32'd42);
      check_eq("post_valid",  out_valid, 1);
      check_eq("post_wen",    wen_out,   1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_alu_ex_stage
`default_nettype wire
